// File: rtl/clk_div_prog_if.sv
// Bus between a controller and clk_div_prog: run request, config strobe and
// the divided-clock status outputs.
interface clk_div_prog_if #(
    parameter int CNT_W = 8
);
    // cfg_vld is a one-cycle strobe with no ready: every strobe is consumed
    // at the posedge that samples it and is either accepted (applied or made
    // pending) or rejected with a one-cycle cfg_err on the following cycle.
    logic             en;
    logic             cfg_vld;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_mode;
    logic             clk_out;
    logic             tick;
    logic             active;
    logic             cfg_pend;
    logic             cfg_err;
    logic             run_dbg;

    modport master (
        output en, cfg_vld, cfg_div, cfg_mode,
        input  clk_out, tick, active, cfg_pend, cfg_err, run_dbg
    );

    modport slave (
        input  en, cfg_vld, cfg_div, cfg_mode,
        output clk_out, tick, active, cfg_pend, cfg_err, run_dbg
    );
endinterface

// File: rtl/clk_div_prog.sv
// Programmable clock divider: pulse or 50% duty output, with config changes
// deferred to period boundaries so the output never glitches.
module clk_div_prog #(
    parameter int CNT_W    = 8,
    parameter int DEF_DIV  = 4,
    parameter int DEF_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    clk_div_prog_if.slave   bus
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] DEF_DIV_V  = CNT_W'(DEF_DIV);
    localparam logic             DEF_MODE_V = (DEF_MODE != 0);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO        = CNT_W'(2);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [CNT_W-1:0] act_div, div_n;
    logic             act_mode, mode_n;
    logic [CNT_W-1:0] pend_div, pdiv_n;
    logic             pend_mode, pmode_n;
    logic             pend, pend_n;
    logic             err, err_n;
    logic             tick, tick_n;
    logic             clk_p, clk_p_n;
    logic             clk_n;
    logic             cfg_ok, last, apply;
    logic [CNT_W-1:0] high_cnt;

    assign cfg_ok = bus.cfg_vld && (bus.cfg_div >= TWO);
    assign last   = (state == RUN) && (cnt == act_div - ONE);
    assign apply  = (state == IDLE) || last;

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        div_n    = act_div;
        mode_n   = act_mode;
        pdiv_n   = pend_div;
        pmode_n  = pend_mode;
        pend_n   = pend;
        tick_n   = 1'b0;
        err_n    = bus.cfg_vld && !cfg_ok;
        high_cnt = ONE;
        clk_p_n  = 1'b0;

        // A strobe on the application edge beats any older pending config.
        if (apply) begin
            if (cfg_ok) begin
                div_n  = bus.cfg_div;
                mode_n = bus.cfg_mode;
            end else if (pend) begin
                div_n  = pend_div;
                mode_n = pend_mode;
            end
            pend_n = 1'b0;
        end else if (cfg_ok) begin
            pdiv_n  = bus.cfg_div;
            pmode_n = bus.cfg_mode;
            pend_n  = 1'b1;
        end

        case (state)
            IDLE: begin
                if (bus.en) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    tick_n  = 1'b1;
                end
            end
            RUN: begin
                if (last) begin
                    cnt_n = '0;
                    if (bus.en) tick_n  = 1'b1;
                    else        state_n = IDLE;
                end else begin
                    cnt_n = cnt + ONE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Floor of N/2 covers both even and odd ratios; the odd half-cycle
        // is added on the negedge path.
        high_cnt = mode_n ? (div_n >> 1) : ONE;
        clk_p_n  = (state_n == RUN) && (cnt_n < high_cnt);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            act_div   <= DEF_DIV_V;
            act_mode  <= DEF_MODE_V;
            pend_div  <= DEF_DIV_V;
            pend_mode <= DEF_MODE_V;
            pend      <= 1'b0;
            err       <= 1'b0;
            tick      <= 1'b0;
            clk_p     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            act_div   <= div_n;
            act_mode  <= mode_n;
            pend_div  <= pdiv_n;
            pend_mode <= pmode_n;
            pend      <= pend_n;
            err       <= err_n;
            tick      <= tick_n;
            clk_p     <= clk_p_n;
        end
    end

    always_ff @(negedge clk or negedge rst) begin
        if (!rst) clk_n <= 1'b0;
        else      clk_n <= clk_p;
    end

    // act_* only change at a boundary, so the odd-half select is stable
    // for a whole period.
    assign bus.clk_out  = clk_p | (clk_n & act_mode & act_div[0]);
    assign bus.tick     = tick;
    assign bus.active   = (state == RUN);
    assign bus.cfg_pend = pend;
    assign bus.cfg_err  = err;
    assign bus.run_dbg  = (state == RUN);
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 SHALL provide parameter CNT_W, default 8, width of divide ratio and counter.
REQ-002 SHALL provide parameter DEF_DIV, default 4, active divide ratio after reset (2 <= DEF_DIV <= 2^CNT_W-1).
REQ-003 SHALL provide parameter DEF_MODE, default 0, active mode after reset (0 = pulse, 1 = 50% duty).
REQ-004 SHALL have port clk  input  1  source clock; all logic on posedge except REQ-022.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  input  1  run request, level.
REQ-007 SHALL have port cfg_vld  input  1  single-cycle strobe qualifying cfg_div/cfg_mode.
REQ-008 SHALL have port cfg_div  input  CNT_W  requested divide ratio N.
REQ-009 SHALL have port cfg_mode  input  1  requested mode.
REQ-010 SHALL have port clk_out  output  1  divided clock.
REQ-011 SHALL have port tick  output  1  registered one-cycle pulse marking each period start.
REQ-012 SHALL have port active  output  1  high while state is RUN.
REQ-013 SHALL have port cfg_pend  output  1  high while an accepted config awaits application.
REQ-014 SHALL have port cfg_err  output  1  registered one-cycle pulse on rejected config.

Function
REQ-015 SHALL implement two states, IDLE and RUN; RUN holds counter cnt counting 0..N-1 (N = active ratio), wrapping N-1 -> 0.
REQ-016 SHALL define high-count H: mode 0 -> H=1; mode 1, N even -> H=N/2; mode 1, N odd -> H=(N-1)/2.
REQ-017 SHALL drive registered clk_p = 1 exactly in cycles where RUN and cnt < H, derived from next-state cnt so clk_p aligns with cnt.
REQ-018 IDLE -> RUN at the posedge sampling en=1: cnt <= 0, clk_p <= 1, tick <= 1, active <= 1.
REQ-019 In RUN, en=0 SHALL take effect only at the posedge where cnt == N-1: state <= IDLE, clk_p <= 0, active <= 0; en=0 elsewhere SHALL not shorten the period.
REQ-020 In RUN at the cnt == N-1 posedge with en=1, cnt <= 0 and tick <= 1; no gap between periods.
REQ-021 SHALL reject cfg_vld with cfg_div < 2: cfg_err pulses next cycle, pending and active config unchanged.
REQ-022 SHALL capture clk_p on negedge clk into clk_n; clk_out = clk_p OR (clk_n AND odd_half), odd_half = mode 1 and N odd; otherwise clk_out = clk_p.
REQ-023 Mode 1, N odd SHALL yield clk_out high N/2 clk periods (half-cycle resolution), low N/2.
REQ-024 Valid cfg_vld SHALL load the pending register and set cfg_pend; a later valid cfg_vld before application overwrites it.
REQ-025 Pending config SHALL become active at the next period boundary (cnt == N-1 posedge in RUN) or the next posedge in IDLE; cfg_pend clears there.
REQ-026 Valid cfg_vld coincident with a boundary/IDLE posedge SHALL apply that cfg directly to the new period, cfg_pend stays 0.
REQ-027 Config change SHALL never produce an output pulse shorter than min(old, new) high or low time (glitch-free).
REQ-028 Odd-half selection SHALL update with the active config at the boundary, never mid-period.

Reset
REQ-029 rst=0 SHALL immediately force state IDLE, cnt 0, clk_p 0, clk_n 0, clk_out 0, tick 0, active 0, cfg_pend 0, cfg_err 0, active config = DEF_DIV/DEF_MODE.
REQ-030 Reset asserted mid-period SHALL discard pending config; after release, first RUN entry SHALL require en sampled 1.

Verification
REQ-031 Defaults, en=1 from reset release -> clk_out high 1 cycle every 4, tick coincident with each rising edge, first high 1 cycle after en sampled.
REQ-032 cfg N=6 mode 1 in IDLE, en=1 -> clk_out 3 high / 3 low; N=5 mode 1 -> rising on posedge, falling on negedge after 2.5 cycles, period 5.
REQ-033 Running N=4 mode 0, cfg N=7 mode 1 at cnt=1 -> cfg_pend 1 until boundary, current period completes at 4, next period 7 with 3.5-cycle high.
REQ-034 cfg_div=0 and cfg_div=1 strobes -> cfg_err pulse each, cfg_pend 0, output unchanged.
REQ-035 en dropped at cnt=1 of N=8 -> output continues to cnt=7, then IDLE, clk_out 0, active 0; en re-raised at cnt=3 of a fresh run -> no interruption.
REQ-036 rst pulsed low mid-high-phase with pending cfg -> clk_out 0 within same time step, cfg_pend 0, restart uses DEF_DIV.
